branch_resolve: RTL and testbench

- Execute-stage branch resolution unit, directly downstream of the branch comparator.
- Takes the comparator's 1-bit result plus the branch PC, target and fetch-time prediction. Decides whether the branch was mispredicted.
- On a mispredict, issues a registered one-cycle redirect/flush to fetch, then squashes wrong-path instructions for a fixed shadow window.
- Owns the 2-bit saturating-counter branch history table (BHT). Fetch reads the BHT combinationally through a lookup port.

---
 rtl/branch_resolve.sv | 136 +++++++++++++
 tb/tb_branch_resolve.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: mispredict detection, one-cycle redirect, shadow squash, 2-bit BHT.
// Optional event counters enabled by defining BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned BHT_ENTRIES   = 64,
  parameter int unsigned SHADOW_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_is_branch,
  input  logic                  i_is_jump,
  input  logic                  i_cmp_res,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic [ADDR_WIDTH-1:0] i_target,
  input  logic                  i_pred_taken,
  input  logic                  i_stall,
  input  logic [ADDR_WIDTH-1:0] i_fetch_pc,
  output logic                  o_pred_taken,
  output logic                  o_redirect,
  output logic [ADDR_WIDTH-1:0] o_redirect_pc
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]           o_branch_cnt,
  output logic [31:0]           o_mispred_cnt,
  output logic [31:0]           o_squash_cnt
`endif
);

  localparam int unsigned IDX = $clog2(BHT_ENTRIES);
  localparam int unsigned CW  = $clog2(SHADOW_CYCLES + 1);

  typedef enum logic {RUN, SHADOW} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    redir_q, redir_d;
  logic [ADDR_WIDTH-1:0]   rpc_q, rpc_d;
  logic [1:0]              bht_q [BHT_ENTRIES];

  logic [IDX-1:0]          ex_idx, f_idx;
  logic                    resolve, taken, is_cond, mispred, bht_we;
  logic [1:0]              ctr_old, ctr_new;
  logic [ADDR_WIDTH-1:0]   correct_pc;
  logic                    unused_fetch;

  assign ex_idx       = i_pc[IDX+1:2];
  assign f_idx        = i_fetch_pc[IDX+1:2];
  assign unused_fetch = ^i_fetch_pc;

  // Reads the registered table, so a same-cycle update is seen only next cycle.
  assign o_pred_taken  = bht_q[f_idx][1];
  assign o_redirect    = redir_q;
  assign o_redirect_pc = rpc_q;

  always_comb begin
    resolve    = (state_q == RUN) && i_valid && !i_stall && (i_is_branch || i_is_jump);
    taken      = i_is_jump | i_cmp_res;
    is_cond    = i_is_branch & ~i_is_jump;
    mispred    = taken ^ i_pred_taken;
    correct_pc = taken ? i_target : i_pc + ADDR_WIDTH'(4);
    ctr_old    = bht_q[ex_idx];
    ctr_new    = ctr_old;
    if (taken && ctr_old != 2'b11)
      ctr_new = ctr_old + 2'd1;
    else if (!taken && ctr_old != 2'b00)
      ctr_new = ctr_old - 2'd1;
    bht_we     = resolve & is_cond;

    state_d = state_q;
    cnt_d   = cnt_q;
    redir_d = 1'b0;
    rpc_d   = rpc_q;
    case (state_q)
      RUN: begin
        if (resolve && mispred) begin
          redir_d = 1'b1;
          rpc_d   = correct_pc;
          cnt_d   = CW'(SHADOW_CYCLES);
          state_d = SHADOW;
        end
      end
      SHADOW: begin
        if (!i_stall) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[ex_idx] <= ctr_new;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q, sq_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      sq_cnt_q  <= '0;
    end else begin
      if (resolve)             br_cnt_q  <= br_cnt_q + 32'd1;
      if (resolve && mispred)  mis_cnt_q <= mis_cnt_q + 32'd1;
      if (state_q == SHADOW && i_valid && !i_stall)
        sq_cnt_q <= sq_cnt_q + 32'd1;
    end
  end

  assign o_branch_cnt  = br_cnt_q;
  assign o_mispred_cnt = mis_cnt_q;
  assign o_squash_cnt  = sq_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, reset corner cases, random vs. model.
module tb_branch_resolve;
  localparam int SHADOW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, is_br, is_jmp, cmp, pred_in, stall;
  logic [31:0] pc, tgt, fpc;
  logic        pred_out, redir;
  logic [31:0] rpc;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] br_cnt, mis_cnt, sq_cnt;
`endif

  branch_resolve #(.ADDR_WIDTH(32), .BHT_ENTRIES(64), .SHADOW_CYCLES(SHADOW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_is_branch(is_br), .i_is_jump(is_jmp),
    .i_cmp_res(cmp), .i_pc(pc), .i_target(tgt), .i_pred_taken(pred_in), .i_stall(stall),
    .i_fetch_pc(fpc), .o_pred_taken(pred_out), .o_redirect(redir), .o_redirect_pc(rpc)
`ifdef BRANCH_RESOLVE_STATS_EN
    , .o_branch_cnt(br_cnt), .o_mispred_cnt(mis_cnt), .o_squash_cnt(sq_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        valid, br, jmp, cmp;
    logic [31:0] pc, tgt;
    logic        pred, stall;
    logic [31:0] fpc;
    logic        e_pred, e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic b, logic j, logic c, logic [31:0] p, logic [31:0] t,
                              logic pr, logic s, logic [31:0] f, logic ep, logic er, logic [31:0] erpc);
    vec_t r;
    r.valid = v; r.br = b; r.jmp = j; r.cmp = c; r.pc = p; r.tgt = t;
    r.pred = pr; r.stall = s; r.fpc = f; r.e_pred = ep; r.e_redir = er; r.e_rpc = erpc;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    valid = v.valid; is_br = v.br; is_jmp = v.jmp; cmp = v.cmp; pc = v.pc; tgt = v.tgt;
    pred_in = v.pred; stall = v.stall; fpc = v.fpc;
  endtask

  task automatic idle();
    valid = 0; is_br = 0; is_jmp = 0; cmp = 0; pc = '0; tgt = '0; pred_in = 0; stall = 0; fpc = '0;
  endtask

  // Behavioural reference: counters as small integers, shadow as a countdown of free cycles.
  int          m_bht [64];
  int          m_shadow;
  logic        m_redir;
  logic [31:0] m_rpc;
  int          m_br, m_mis, m_sq;

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_shadow = 0; m_redir = 0; m_rpc = '0; m_br = 0; m_mis = 0; m_sq = 0;
  endtask

  task automatic model_step();
    logic        tk;
    logic [31:0] cpc;
    int          i;
    m_redir = 0;
    if (m_shadow > 0) begin
      if (!stall) begin
        if (valid) m_sq++;
        m_shadow--;
      end
    end else if (valid && !stall && (is_br || is_jmp)) begin
      tk  = is_jmp | cmp;
      cpc = tk ? tgt : pc + 32'd4;
      i   = int'((pc >> 2) % 64);
      m_br++;
      if (is_br && !is_jmp) m_bht[i] = tk ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3)
                                          : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
      if (tk != pred_in) begin
        m_redir = 1; m_rpc = cpc; m_shadow = SHADOW; m_mis++;
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    int          idx;
    logic        exp_p;

    idle();
    rst = 1;
    fpc = 32'h100;
    #3;
    chk("reset_pred", {31'b0, pred_out}, 32'd0);
    chk("reset_redir", {31'b0, redir}, 32'd0);
    chk("reset_rpc", rpc, 32'd0);
    @(posedge clk); #2;
    rst = 0;
    @(posedge clk); #1;

    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,0, 32'h100, 0,0, 32'h0));
    vecs.push_back(mk(1,1,0,1, 32'h100,     32'h200, 0,0, 32'h100, 0,1, 32'h200));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,0, 32'h100, 1,0, 32'h200));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,0, 32'h100, 1,0, 32'h200));
    vecs.push_back(mk(1,1,0,0, 32'h100,     32'h200, 1,0, 32'h100, 1,1, 32'h104));
    vecs.push_back(mk(1,1,0,1, 32'h100,     32'h200, 0,0, 32'h100, 0,0, 32'h104));
    vecs.push_back(mk(1,1,0,1, 32'h100,     32'h200, 0,0, 32'h100, 0,0, 32'h104));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,0, 32'h100, 0,0, 32'h104));
    vecs.push_back(mk(1,1,0,1, 32'h100,     32'h200, 1,0, 32'h100, 0,0, 32'h104));
    vecs.push_back(mk(1,1,0,1, 32'h100,     32'h200, 1,0, 32'h100, 1,0, 32'h104));
    vecs.push_back(mk(1,1,0,1, 32'h100,     32'h200, 1,0, 32'h100, 1,0, 32'h104));
    vecs.push_back(mk(1,1,0,1, 32'h100,     32'h200, 1,0, 32'h100, 1,0, 32'h104));
    vecs.push_back(mk(1,1,0,0, 32'h100,     32'h200, 0,0, 32'h100, 1,0, 32'h104));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,0, 32'h100, 1,0, 32'h104));
    vecs.push_back(mk(1,0,1,0, 32'hFFFFFFFC,32'h40,  0,0, 32'hFFFFFFFC, 0,1, 32'h40));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,0, 32'hFFFFFFFC, 0,0, 32'h40));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,0, 32'hFFFFFFFC, 0,0, 32'h40));
    vecs.push_back(mk(1,1,0,0, 32'hFFFFFFFC,32'h40,  1,0, 32'hFFFFFFFC, 0,1, 32'h0));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,1, 32'h100, 1,0, 32'h0));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,1, 32'h100, 1,0, 32'h0));
    vecs.push_back(mk(0,0,0,0, 32'h0,       32'h0,   0,1, 32'h100, 1,0, 32'h0));
    vecs.push_back(mk(1,1,0,0, 32'h100,     32'h200, 1,0, 32'h100, 1,0, 32'h0));
    vecs.push_back(mk(1,1,0,0, 32'h100,     32'h200, 1,0, 32'h100, 1,0, 32'h0));
    vecs.push_back(mk(1,1,0,0, 32'h100,     32'h200, 1,0, 32'h100, 1,1, 32'h104));

    foreach (vecs[k]) begin
      drive(vecs[k]);
      #1;
      chk($sformatf("vec%0d_pred", k), {31'b0, pred_out}, {31'b0, vecs[k].e_pred});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_redir", k), {31'b0, redir}, {31'b0, vecs[k].e_redir});
      chk($sformatf("vec%0d_rpc", k), rpc, vecs[k].e_rpc);
    end

    // Reset during the redirect cycle: pulse dropped, next mispredict must redirect at once.
    idle();
    #2 rst = 1;
    #1;
    chk("midrst_redir", {31'b0, redir}, 32'd0);
    chk("midrst_rpc", rpc, 32'd0);
    rst = 0;
    drive(mk(1,1,0,1, 32'h100, 32'h200, 0,0, 32'h100, 0,1, 32'h200));
    @(posedge clk); #1;
    chk("postrst_redir", {31'b0, redir}, 32'd1);
    chk("postrst_rpc", rpc, 32'h200);

    // Randomised phase against the model.
    idle();
    rst = 1;
    model_reset();
    @(posedge clk); #2;
    rst = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 600; n++) begin
      r      = $urandom();
      idx    = $urandom_range(0, 7);
      valid  = ($urandom_range(0, 9) < 7);
      is_br  = ($urandom_range(0, 9) < 7);
      is_jmp = ($urandom_range(0, 9) < 2);
      cmp    = $urandom_range(0, 1);
      pred_in = $urandom_range(0, 1);
      stall  = ($urandom_range(0, 9) < 2);
      pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {r[31:8], 1'b0, idx[2:0], 2'b00};
      tgt    = $urandom();
      r      = $urandom();
      idx    = $urandom_range(0, 7);
      fpc    = {r[31:8], 1'b0, idx[2:0], r[1:0]};
      #1;
      exp_p = (m_bht[int'((fpc >> 2) % 64)] >= 2);
      chk("rnd_pred", {31'b0, pred_out}, {31'b0, exp_p});
      model_step();
      @(posedge clk); #1;
      chk("rnd_redir", {31'b0, redir}, {31'b0, m_redir});
      chk("rnd_rpc", rpc, m_rpc);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("rnd_br_cnt", br_cnt, 32'(m_br));
      chk("rnd_mis_cnt", mis_cnt, 32'(m_mis));
      chk("rnd_sq_cnt", sq_cnt, 32'(m_sq));
`endif
    end

    // Every counter must return to weakly not-taken on reset.
    idle();
    rst = 1;
    for (int e = 0; e < 64; e++) begin
      fpc = 32'(e) << 2;
      #1;
      chk("rst_sweep_pred", {31'b0, pred_out}, 32'd0);
    end
    chk("rst_sweep_redir", {31'b0, redir}, 32'd0);
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
